// File: rtl/trigger_capture_pkg.sv
// trigger_pkg: shared definitions for the trigger capture block.
//   state_t  - capture FSM encoding, also reported on sts_state
//   EVT_TRG  - sample event bit that fires the trigger
//   EVT_STP  - sample event bit that ends the post-trigger phase early
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int EVT_TRG = 0;
  localparam int EVT_STP = 1;

endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: the two sample streams around the capture block.
//   sti_* - sample stream from the trigger stage (data + event bits)
//   sto_* - framed capture stream towards storage/readout (tlast on final word)
// Modports:
//   slave  - the capture block (sinks sti, sources sto)
//   master - the environment (sources sti, sinks sto)
interface trigger_capture_if #(
  parameter int SDW = 32,
  parameter int SEW = 2
);

  logic           sti_tready;
  logic           sti_tvalid;
  logic [SEW-1:0] sti_tevent;
  logic [SDW-1:0] sti_tdata;

  logic           sto_tready;
  logic           sto_tvalid;
  logic           sto_tlast;
  logic [SDW-1:0] sto_tdata;

  modport slave (
    input  sti_tvalid, sti_tevent, sti_tdata, sto_tready,
    output sti_tready, sto_tvalid, sto_tlast, sto_tdata
  );

  modport master (
    output sti_tvalid, sti_tevent, sti_tdata, sto_tready,
    input  sti_tready, sto_tvalid, sto_tlast, sto_tdata
  );

endinterface

// File: rtl/trigger_capture_ram.sv
// trigger_capture_ram: simple dual-port RAM with synchronous read.
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read request; rdata updates on the next edge only when re=1,
//                  otherwise it holds the previous word
//   rdata        - registered read data
module trigger_capture_ram #(
  parameter int DATA_W = 33,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: keeps a rolling pre-trigger history while armed and, on the
// trigger event, emits that history plus cfg_post further samples as one
// framed stream.
//   clk, rst       - clock, asynchronous active-low reset
//   ctl_arm        - single-cycle arm request (honoured only in IDLE)
//   ctl_abort      - single-cycle abort, highest priority
//   cfg_pre        - pre-trigger depth, sampled on arm
//   cfg_post       - samples captured after the trigger sample, sampled on arm
//   sts_state      - FSM state (IDLE/ARMED/POST/DRAIN)
//   sts_count      - buffer occupancy (words in RAM not yet read out)
//   strm           - sti input stream / sto framed output stream
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int BAW = 10,
  parameter int PCW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctl_arm,
  input  logic           ctl_abort,
  input  logic [BAW-1:0] cfg_pre,
  input  logic [PCW-1:0] cfg_post,
  output logic [1:0]     sts_state,
  output logic [BAW:0]   sts_count,
  trigger_capture_if.slave strm
);

  localparam logic [BAW:0] DEPTH   = {1'b1, {BAW{1'b0}}};
  localparam logic [BAW:0] PTR_ONE = {{BAW{1'b0}}, 1'b1};

  function automatic logic [PCW-1:0] sat_dec(input logic [PCW-1:0] v);
    return (v == '0) ? v : v - {{(PCW-1){1'b0}}, 1'b1};
  endfunction

  state_t         state, state_nxt;
  logic [BAW:0]   wr_ptr, rd_ptr, count;
  logic [BAW-1:0] pre_q;
  logic [PCW-1:0] post_q, post_cnt, post_cnt_nxt, post_dec;
  logic           full, arm_ok, push, pop, drop, mark_last, in_ready;
  logic           out_ready, out_xfer;
  logic [SDW:0]   rdata_p1;
  logic           vld_p1, vld_p2, last_p2;
  logic [SDW-1:0] data_p2;

  // Pointers carry a wrap bit, so occupancy is a plain difference and
  // full/empty are unambiguous.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == DEPTH);
  assign out_ready = ~vld_p2 | strm.sto_tready;
  assign out_xfer  = vld_p2 & strm.sto_tready;
  assign post_dec  = sat_dec(post_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    arm_ok       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    drop         = 1'b0;
    mark_last    = 1'b0;
    in_ready     = 1'b1;
    case (state)
      IDLE: begin
        if (ctl_arm) begin
          arm_ok    = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (strm.sti_tvalid) begin
          push = 1'b1;
          if (strm.sti_tevent[EVT_TRG]) begin
            post_cnt_nxt = post_q;
            if (post_q == '0) begin
              mark_last = 1'b1;
              state_nxt = DRAIN;
            end else begin
              state_nxt = POST;
            end
          end else begin
            // Occupancy after this write would exceed the pre depth exactly
            // when the current occupancy already equals it: retire the oldest.
            drop = (count >= {1'b0, pre_q});
          end
        end
      end
      POST: begin
        in_ready = ~full;
        pop      = (count != '0) & (~vld_p1 | out_ready);
        if (strm.sti_tvalid && !full) begin
          push         = 1'b1;
          post_cnt_nxt = post_dec;
          if (post_dec == '0 || strm.sti_tevent[EVT_STP]) begin
            mark_last = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        pop = (count != '0) & (~vld_p1 | out_ready);
        if (out_xfer && last_p2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (ctl_abort) begin
      state_nxt = IDLE;
      arm_ok    = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      drop      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      post_cnt <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
    end else if (ctl_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (arm_ok) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pre_q  <= cfg_pre;
        post_q <= cfg_post;
      end else begin
        if (push)        wr_ptr <= wr_ptr + PTR_ONE;
        if (pop || drop) rd_ptr <= rd_ptr + PTR_ONE;
      end
      post_cnt <= post_cnt_nxt;
      vld_p1   <= pop | (vld_p1 & ~out_ready);
      if (out_ready) vld_p2 <= vld_p1;
    end
  end

  // ---- p0 -> p1: RAM write of {last, data}; read issued when p1 can advance
  trigger_capture_ram #(
    .DATA_W (SDW + 1),
    .ADDR_W (BAW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[BAW-1:0]),
    .wdata ({mark_last, strm.sti_tdata}),
    .re    (pop),
    .raddr (rd_ptr[BAW-1:0]),
    .rdata (rdata_p1)
  );

  // ---- p1 -> p2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (out_ready && vld_p1) begin
      data_p2 <= rdata_p1[SDW-1:0];
      last_p2 <= rdata_p1[SDW];
    end
  end

  assign strm.sti_tready = in_ready;
  assign strm.sto_tvalid = vld_p2;
  assign strm.sto_tlast  = vld_p2 & last_p2;
  assign strm.sto_tdata  = data_p2;
  assign sts_state       = state;
  assign sts_count       = count;

endmodule
